// File: rtl/rollo_ii_ct_unpack.sv
// rtl/rollo_ii_ct_unpack.sv - ROLLO-II ciphertext word stream to GF(2^m) coefficient unpacker (optional ROLLO_PAD_CHECK_EN)
module rollo_ii_ct_unpack #(
    parameter int M  = 83,
    parameter int N  = 189,
    parameter int W  = 32,
    parameter int NW = 491
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         coef_we,
    output logic [7:0]   coef_addr,
    output logic [M-1:0] coef_data,
    output logic         busy,
    output logic         ready,
    output logic         pad_err
);

    // Accumulator only ever accepts a word while holding fewer than M bits,
    // so M-1 + W bits is the most it can hold.
    localparam int ACC_W = M + W - 1;
    localparam int CNT_W = $clog2(M + W);
    localparam int WC_W  = $clog2(NW + 1);

    localparam logic [CNT_W-1:0] M_CNT  = CNT_W'(M);
    localparam logic [CNT_W-1:0] W_CNT  = CNT_W'(W);
    localparam logic [WC_W-1:0]  NW_CNT = WC_W'(NW);
    localparam logic [7:0]       N_IDX  = 8'(N);

`ifdef ROLLO_PAD_CHECK_EN
    // Bit position inside the last word where the padding begins.
    localparam int PAD_LO = N * M - (NW - 1) * W;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    logic [WC_W-1:0]  word_cnt;
    logic [7:0]       coef_idx;
    logic [ACC_W-1:0] word_ext;

    assign word_ext = {{(ACC_W - W){1'b0}}, in_data};

    // Accept only when no coefficient is pending and the word budget is not spent.
    assign in_ready = (state == LOAD) && (acc_cnt < M_CNT) && (word_cnt != NW_CNT);

`ifndef ROLLO_PAD_CHECK_EN
    assign pad_err = 1'b0;
`endif

    // Load FSM: emit a coefficient whenever M bits are buffered, otherwise pull a word.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state     <= IDLE;
            acc       <= '0;
            acc_cnt   <= '0;
            word_cnt  <= '0;
            coef_idx  <= '0;
            coef_we   <= 1'b0;
            coef_addr <= '0;
            coef_data <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
`ifdef ROLLO_PAD_CHECK_EN
            pad_err   <= 1'b0;
`endif
        end else begin
            coef_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        acc      <= '0;
                        acc_cnt  <= '0;
                        word_cnt <= '0;
                        coef_idx <= '0;
`ifdef ROLLO_PAD_CHECK_EN
                        pad_err  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (coef_idx == N_IDX) begin
                        // Last coefficient went out the previous cycle; leftover bits are padding.
                        state <= DONE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (acc_cnt >= M_CNT) begin
                        coef_we   <= 1'b1;
                        coef_data <= acc[M-1:0];
                        coef_addr <= coef_idx;
                        acc       <= acc >> M;
                        acc_cnt   <= acc_cnt - M_CNT;
                        coef_idx  <= coef_idx + 8'd1;
                    end else if (in_valid && in_ready) begin
                        acc      <= acc | (word_ext << acc_cnt);
                        acc_cnt  <= acc_cnt + W_CNT;
                        word_cnt <= word_cnt + WC_W'(1);
`ifdef ROLLO_PAD_CHECK_EN
                        if ((word_cnt == NW_CNT - WC_W'(1)) && ((in_data >> PAD_LO) != '0))
                            pad_err <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rollo_ii_ct_unpack.sv
// tb/tb_rollo_ii_ct_unpack.sv - self-checking bench for rollo_ii_ct_unpack
module tb_rollo_ii_ct_unpack;

    localparam int M  = 83;
    localparam int N  = 189;
    localparam int W  = 32;
    localparam int NW = 491;

`ifdef ROLLO_PAD_CHECK_EN
    localparam bit PAD_EXP = 1'b1;
`else
    localparam bit PAD_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_b;
    logic         start;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         coef_we;
    logic [7:0]   coef_addr;
    logic [M-1:0] coef_data;
    logic         busy;
    logic         ready;
    logic         pad_err;

    rollo_ii_ct_unpack #(.M(M), .N(N), .W(W), .NW(NW)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
        .ready(ready), .pad_err(pad_err)
    );

    always #5 clk = ~clk;

    // pat: 0 incrementing, 1 all-ones, 2 zeros with last word 0x80, 3 all zeros
    typedef struct {
        int pat;
        bit toggle;
        int start_at;
        int abort_at;
        int exp_lat;
        int exp_writes;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] words [NW];
    logic [M-1:0] cap_data [256];
    logic [7:0]   cap_addr [256];
    int           cap_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (coef_we) begin
            if (cap_cnt < 256) begin
                cap_data[cap_cnt] = coef_data;
                cap_addr[cap_cnt] = coef_addr;
            end
            cap_cnt++;
        end
    endtask

    function automatic logic [M-1:0] ref_coef(input int i);
        logic [M-1:0] r;
        int p;
        for (int b = 0; b < M; b++) begin
            p = i * M + b;
            r[b] = words[p / W][p % W];
        end
        return r;
    endfunction

    // Cycle-level timing of the fill count: emit when >= M bits, else take a word if offered.
    function automatic int model_lat(input bit toggle);
        int cnt = 0;
        int w = 0;
        int e = 0;
        for (int k = 0; k < 5000; k++) begin
            if (e == N) return k + 1;
            if (cnt >= M) begin
                cnt -= M;
                e++;
            end else if (w < NW && (!toggle || (k % 2 == 0))) begin
                cnt += W;
                w++;
            end
        end
        return -1;
    endfunction

    task automatic fill_words(input int pat);
        for (int j = 0; j < NW; j++) begin
            case (pat)
                0: words[j] = W'(j);
                1: words[j] = '1;
                default: words[j] = '0;
            endcase
        end
        if (pat == 2) words[NW-1] = 32'h0000_0080;
    endtask

    task automatic run(input vec_t v);
        int t, lat, exp_lat, widx, c0;
        bit aborted;
        fill_words(v.pat);
        cap_cnt = 0;
        widx    = 0;
        lat     = -1;
        aborted = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        t       = 0;
        while (t < 3000 && lat < 0 && !aborted) begin
            if (v.abort_at >= 0 && cap_cnt >= v.abort_at) begin
                aborted = 1'b1;
            end else begin
                in_valid = v.toggle ? (t % 2 == 0) : 1'b1;
                start    = (t == v.start_at);
                in_data  = (in_valid && widx < NW) ? words[widx] : 32'hDEAD_BEEF;
                if (widx == NW) check("extra_word_refused", in_ready, 0);
                if (t == 10) begin
                    check("busy_in_load", busy, 1);
                    check("ready_in_load", ready, 0);
                    check("pad_err_cleared_by_start", pad_err, 0);
                end
                if (in_valid && in_ready) widx++;
                tick();
                t++;
                if (ready) lat = t;
            end
        end
        start = 1'b0;
        if (aborted) begin
            rst_b    = 1'b1;
            in_valid = 1'b1;
            tick();
            check("abort_coef_we", coef_we, 0);
            check("abort_busy", busy, 0);
            rst_b = 1'b0;
            c0    = cap_cnt;
            repeat (20) tick();
            check("abort_no_writes", cap_cnt, c0);
            check("abort_busy_idle", busy, 0);
            check("abort_ready", ready, 0);
            check("abort_in_ready", in_ready, 0);
        end else begin
            exp_lat = (v.exp_lat > 0) ? v.exp_lat : model_lat(v.toggle);
            check("ready_latency", lat, exp_lat);
            check("words_accepted", widx, NW);
            check("busy_done", busy, 0);
            check("in_ready_done", in_ready, 0);
            check("pad_err_end", pad_err, (v.pat == 3) ? 1'b0 : PAD_EXP);
        end
        in_valid = 1'b0;
        check("write_count", cap_cnt, v.exp_writes);
        for (int i = 0; i < cap_cnt && i < 256; i++) begin
            check("coef_addr", cap_addr[i], i);
            check("coef_data", cap_data[i], ref_coef(i));
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{pat: 0, toggle: 0, start_at: -1,  abort_at: -1,  exp_lat: 681, exp_writes: 189};
        vecs[1] = '{pat: 0, toggle: 1, start_at: -1,  abort_at: -1,  exp_lat: 0,   exp_writes: 189};
        vecs[2] = '{pat: 0, toggle: 0, start_at: 150, abort_at: -1,  exp_lat: 681, exp_writes: 189};
        vecs[3] = '{pat: 0, toggle: 0, start_at: -1,  abort_at: 100, exp_lat: 0,   exp_writes: 100};
        vecs[4] = '{pat: 1, toggle: 0, start_at: -1,  abort_at: -1,  exp_lat: 681, exp_writes: 189};
        vecs[5] = '{pat: 2, toggle: 0, start_at: -1,  abort_at: -1,  exp_lat: 681, exp_writes: 189};
        vecs[6] = '{pat: 3, toggle: 0, start_at: -1,  abort_at: -1,  exp_lat: 681, exp_writes: 189};

        rst_b    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cap_cnt  = 0;
        repeat (5) tick();
        rst_b    = 1'b0;
        in_valid = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_coef_we", coef_we, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_coef_data", coef_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_pad_err", pad_err, 0);
        check("rst_no_writes", cap_cnt, 0);
        in_valid = 1'b0;

        // Reset and start together: reset wins, block stays idle.
        rst_b = 1'b1;
        start = 1'b1;
        tick();
        rst_b = 1'b0;
        start = 1'b0;
        tick();
        check("rst_over_start_busy", busy, 0);

        for (int k = 0; k < 7; k++) run(vecs[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
